// File: rtl/ex_issue_window_pkg.sv
// Shared types and width helpers for the execution issue window.
package ex_issue_window_pkg;

  // Default configuration of the window.
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_NPHYS     = 64;
  localparam int DEF_PAYLOAD_W = 96;

  // Physical tag width for a given register-file size.
  function automatic int tag_w(input int nphys);
    return $clog2(nphys);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_TW = tag_w(DEF_NPHYS);
  localparam int DEF_CW = count_w(DEF_DEPTH);

  // One window entry at the default configuration.
  typedef struct packed {
    logic [DEF_TW-1:0]        src1;
    logic [DEF_TW-1:0]        src2;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } issue_entry_t;

endpackage

// File: rtl/ex_issue_select.sv
// Priority picker: lowest-index ready entry wins; in-order mode only looks at entry 0.
module ex_issue_select #(
  parameter int DEPTH    = 8,
  parameter bit IN_ORDER = 1'b0
) (
  input  logic [DEPTH-1:0]         rdy,
  output logic [DEPTH-1:0]         sel_oh,
  output logic [$clog2(DEPTH)-1:0] sel_idx,
  output logic                     found
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] cand;

  // Restrict the candidate set to the head entry in in-order mode.
  always_comb begin
    cand = rdy;
    if (IN_ORDER) cand = {{(DEPTH-1){1'b0}}, rdy[0]};
  end

  // Scan from the youngest end so the oldest candidate overwrites last.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_issue_window.sv
// Collapsing, age-ordered issue window with a registered valid/ready output stage.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Enq_Ready depends only on registered occupancy. Iss_Valid/Iss_Src*/
// Iss_Payload come straight from a register and stay stable while Iss_Valid is
// high and Iss_Ready is low.
module ex_issue_window
  import ex_issue_window_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NPHYS     = 64,
  parameter int PAYLOAD_W = 96,
  parameter bit IN_ORDER  = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Flush,
  input  logic                       Enq_Valid,
  output logic                       Enq_Ready,
  input  logic [$clog2(NPHYS)-1:0]   Enq_Src1,
  input  logic [$clog2(NPHYS)-1:0]   Enq_Src2,
  input  logic [PAYLOAD_W-1:0]       Enq_Payload,
  input  logic [NPHYS-1:0]           Wake_List,
  input  logic                       Issue_Hold,
  output logic                       Iss_Valid,
  input  logic                       Iss_Ready,
  output logic [$clog2(NPHYS)-1:0]   Iss_Src1,
  output logic [$clog2(NPHYS)-1:0]   Iss_Src2,
  output logic [PAYLOAD_W-1:0]       Iss_Payload,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);

  localparam int TW = tag_w(NPHYS);
  localparam int CW = count_w(DEPTH);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [TW-1:0]        src1;
    logic [TW-1:0]        src2;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;
  entry_t           iss_q;
  logic             iss_valid_q;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] shift_mask;
  logic [IW-1:0]    sel_idx;
  logic             found;
  logic             can_load;
  logic             deq;
  logic             enq;

  // Entries below Count are live; a live entry is ready when both sources are awake.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = (CW'(i) < count_q) & Wake_List[ent_q[i].src1] & Wake_List[ent_q[i].src2];
    end
  end

  ex_issue_select #(
    .DEPTH    (DEPTH),
    .IN_ORDER (IN_ORDER)
  ) u_select (
    .rdy     (rdy),
    .sel_oh  (sel_oh),
    .sel_idx (sel_idx),
    .found   (found)
  );

  // Load the output stage when it is empty or draining this cycle, unless held.
  always_comb begin
    can_load = !Issue_Hold & (!iss_valid_q | Iss_Ready);
    deq      = can_load & found;
    enq      = Enq_Valid & Enq_Ready;
    wr_idx   = count_q - CW'(deq);
  end

  // Entries at or above the selected slot move down one position on dequeue.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc           = acc | sel_oh[i];
      shift_mask[i] = acc;
    end
  end

  // Next array contents: collapse behind the dequeued entry, then append at the tail.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (deq) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (shift_mask[i]) ent_d[i] = ent_q[i+1];
      end
      if (shift_mask[DEPTH-1]) ent_d[DEPTH-1] = '0;
      count_d = count_d - CW'(1);
    end
    if (enq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) ent_d[i] = '{src1: Enq_Src1, src2: Enq_Src2, payload: Enq_Payload};
      end
      count_d = count_d + CW'(1);
    end
  end

  // Window storage and occupancy; flush drops every live entry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (Flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Output stage: load on dequeue, clear after a handshake with nothing to replace it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
    end else if (Flush) begin
      iss_valid_q <= 1'b0;
    end else if (deq) begin
      iss_q       <= ent_q[sel_idx];
      iss_valid_q <= 1'b1;
    end else if (iss_valid_q && Iss_Ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  // Status and output drive.
  always_comb begin
    Count       = count_q;
    Full        = (count_q == CW'(DEPTH));
    Empty       = (count_q == '0);
    Enq_Ready   = !Full;
    Iss_Valid   = iss_valid_q;
    Iss_Src1    = iss_q.src1;
    Iss_Src2    = iss_q.src2;
    Iss_Payload = iss_q.payload;
  end

endmodule

// File: tb/tb_ex_issue_window.sv
// Bench for ex_issue_window: one out-of-order and one in-order instance share stimulus.
module tb_ex_issue_window;

  localparam int DEPTH = 8;
  localparam int NPHYS = 64;
  localparam int PW    = 96;
  localparam int TW    = 6;
  localparam int CW    = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic             Clk         = 1'b0;
  logic             Rst         = 1'b0;
  logic             Flush       = 1'b0;
  logic             Enq_Valid   = 1'b0;
  logic             Issue_Hold  = 1'b0;
  logic             Iss_Ready   = 1'b0;
  logic [TW-1:0]    Enq_Src1    = '0;
  logic [TW-1:0]    Enq_Src2    = '0;
  logic [PW-1:0]    Enq_Payload = '0;
  logic [NPHYS-1:0] Wake_List   = '1;

  logic [1:0]       enq_ready;
  logic [1:0]       iss_valid;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [TW-1:0]    iss_src1    [2];
  logic [TW-1:0]    iss_src2    [2];
  logic [PW-1:0]    iss_payload [2];
  logic [CW-1:0]    count       [2];

  always #5 Clk = ~Clk;

  ex_issue_window #(.DEPTH(DEPTH), .NPHYS(NPHYS), .PAYLOAD_W(PW), .IN_ORDER(1'b0)) u_ooo (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .Enq_Valid(Enq_Valid), .Enq_Ready(enq_ready[0]),
    .Enq_Src1(Enq_Src1), .Enq_Src2(Enq_Src2), .Enq_Payload(Enq_Payload), .Wake_List(Wake_List),
    .Issue_Hold(Issue_Hold), .Iss_Valid(iss_valid[0]), .Iss_Ready(Iss_Ready),
    .Iss_Src1(iss_src1[0]), .Iss_Src2(iss_src2[0]), .Iss_Payload(iss_payload[0]),
    .Count(count[0]), .Full(full[0]), .Empty(empty[0])
  );

  ex_issue_window #(.DEPTH(DEPTH), .NPHYS(NPHYS), .PAYLOAD_W(PW), .IN_ORDER(1'b1)) u_ino (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .Enq_Valid(Enq_Valid), .Enq_Ready(enq_ready[1]),
    .Enq_Src1(Enq_Src1), .Enq_Src2(Enq_Src2), .Enq_Payload(Enq_Payload), .Wake_List(Wake_List),
    .Issue_Hold(Issue_Hold), .Iss_Valid(iss_valid[1]), .Iss_Ready(Iss_Ready),
    .Iss_Src1(iss_src1[1]), .Iss_Src2(iss_src2[1]), .Iss_Payload(iss_payload[1]),
    .Count(count[1]), .Full(full[1]), .Empty(empty[1])
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int k, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The window is an age-ordered list; the output stage is a single slot.
  typedef struct packed {
    logic [TW-1:0] s1;
    logic [TW-1:0] s2;
    logic [PW-1:0] pay;
  } m_ent_t;

  m_ent_t mq    [2][$];
  m_ent_t m_iss [2];
  logic   m_iv  [2];

  always @(posedge Clk or negedge Rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!Rst) begin
        mq[k].delete();
        m_iv[k]  = 1'b0;
        m_iss[k] = '0;
      end else if (Flush) begin
        mq[k].delete();
        m_iv[k] = 1'b0;
      end else begin
        int     pick;
        bit     take_new;
        m_ent_t nw;
        pick     = -1;
        take_new = Enq_Valid && (mq[k].size() < DEPTH);
        nw       = '{s1: Enq_Src1, s2: Enq_Src2, pay: Enq_Payload};
        for (int i = 0; i < mq[k].size(); i++) begin
          if (k == 1 && i > 0) break;
          if (Wake_List[mq[k][i].s1] && Wake_List[mq[k][i].s2]) begin
            pick = i;
            break;
          end
        end
        if (!Issue_Hold && (!m_iv[k] || Iss_Ready) && pick >= 0) begin
          m_iss[k] = mq[k][pick];
          m_iv[k]  = 1'b1;
          mq[k].delete(pick);
        end else if (m_iv[k] && Iss_Ready) begin
          m_iv[k] = 1'b0;
        end
        if (take_new) mq[k].push_back(nw);
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("count",     k, PW'(count[k]),     PW'(mq[k].size()));
      chk("full",      k, PW'(full[k]),      PW'(mq[k].size() == DEPTH));
      chk("empty",     k, PW'(empty[k]),     PW'(mq[k].size() == 0));
      chk("enq_ready", k, PW'(enq_ready[k]), PW'(mq[k].size() < DEPTH));
      chk("iss_valid", k, PW'(iss_valid[k]), PW'(m_iv[k]));
      if (m_iv[k]) begin
        chk("iss_src1",    k, PW'(iss_src1[k]), PW'(m_iss[k].s1));
        chk("iss_src2",    k, PW'(iss_src2[k]), PW'(m_iss[k].s2));
        chk("iss_payload", k, iss_payload[k],   m_iss[k].pay);
      end
    end
  end

  // ---------------- scoreboard: hand-written issue order ----------------
  logic [PW-1:0] exp_q    [$];
  logic [PW-1:0] exp_q_io [$];

  always @(negedge Clk) begin
    if (Rst && !Flush && Iss_Ready) begin
      if (iss_valid[0]) begin
        if (exp_q.size() == 0) chk("unexpected_issue", 0, iss_payload[0], '0);
        else chk("issue_order", 0, iss_payload[0], exp_q.pop_front());
      end
      if (iss_valid[1]) begin
        if (exp_q_io.size() == 0) chk("unexpected_issue", 1, iss_payload[1], '0);
        else chk("issue_order", 1, iss_payload[1], exp_q_io.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic enq(input logic [TW-1:0] s1, input logic [TW-1:0] s2, input logic [PW-1:0] p);
    Enq_Valid   = 1'b1;
    Enq_Src1    = s1;
    Enq_Src2    = s2;
    Enq_Payload = p;
    step();
    Enq_Valid   = 1'b0;
  endtask

  task automatic expect_both(input logic [PW-1:0] p);
    exp_q.push_back(p);
    exp_q_io.push_back(p);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (count[0] == '0 && count[1] == '0 && iss_valid == 2'b00 &&
          exp_q.size() == 0 && exp_q_io.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(nm, 0, PW'(done), PW'(1'b1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_count",     k, PW'(count[k]),     '0);
      chk("rst_empty",     k, PW'(empty[k]),     PW'(1));
      chk("rst_full",      k, PW'(full[k]),      '0);
      chk("rst_enq_ready", k, PW'(enq_ready[k]), PW'(1));
      chk("rst_iss_valid", k, PW'(iss_valid[k]), '0);
      chk("rst_payload",   k, iss_payload[k],    '0);
    end
    Rst = 1'b1;
    step();

    // Basic in-order flow with everything awake, two-edge latency.
    Wake_List = '1;
    Iss_Ready = 1'b1;
    expect_both(96'hA);
    expect_both(96'hB);
    expect_both(96'hC);
    enq(6'd1, 6'd2, 96'hA);
    @(negedge Clk);
    chk("lat_edge_n", 0, PW'(iss_valid[0]), '0);
    enq(6'd3, 6'd4, 96'hB);
    @(negedge Clk);
    chk("lat_edge_n1_valid", 0, PW'(iss_valid[0]), PW'(1));
    chk("lat_edge_n1_pay",   0, iss_payload[0],    96'hA);
    chk("lat_edge_n1_pay",   1, iss_payload[1],    96'hA);
    enq(6'd5, 6'd6, 96'hC);
    wait_drain(40, "drain_basic");
    chk("basic_count", 0, PW'(count[0]), '0);
    chk("basic_empty", 0, PW'(empty[0]), PW'(1));

    // Oldest entry blocked on tag 5: OOO bypasses it, in-order waits.
    Wake_List[5] = 1'b0;
    exp_q.push_back(96'hB2);
    exp_q.push_back(96'hC2);
    exp_q.push_back(96'hA2);
    exp_q_io.push_back(96'hA2);
    exp_q_io.push_back(96'hB2);
    exp_q_io.push_back(96'hC2);
    enq(6'd5, 6'd1, 96'hA2);
    enq(6'd2, 6'd3, 96'hB2);
    enq(6'd4, 6'd6, 96'hC2);
    repeat (6) step();
    chk("ooo_bypass_count", 0, PW'(count[0]),     PW'(1));
    chk("ooo_bypass_valid", 0, PW'(iss_valid[0]), '0);
    chk("io_blocked_count", 1, PW'(count[1]),     PW'(3));
    chk("io_blocked_valid", 1, PW'(iss_valid[1]), '0);
    Wake_List[5] = 1'b1;
    wait_drain(40, "drain_ooo");

    // Fill to capacity; the ninth offer is refused, also on the dequeue cycle.
    Wake_List[5] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_both(PW'(32'h300 + i));
      enq(6'd5, 6'd5, PW'(32'h300 + i));
    end
    Enq_Valid   = 1'b1;
    Enq_Src1    = 6'd1;
    Enq_Src2    = 6'd1;
    Enq_Payload = 96'h3FF;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk("full_count",     k, PW'(count[k]),     PW'(8));
      chk("full_flag",      k, PW'(full[k]),      PW'(1));
      chk("full_enq_ready", k, PW'(enq_ready[k]), '0);
    end
    Wake_List[5] = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("deq_when_full_count", k, PW'(count[k]),     PW'(7));
      chk("deq_when_full_ready", k, PW'(enq_ready[k]), PW'(1));
    end
    Enq_Valid = 1'b0;
    wait_drain(60, "drain_full");

    // Output stalled by the EX pipe, then drained under Issue_Hold.
    Iss_Ready = 1'b0;
    expect_both(96'hD);
    expect_both(96'hE);
    expect_both(96'hF);
    enq(6'd1, 6'd1, 96'hD);
    enq(6'd2, 6'd2, 96'hE);
    enq(6'd3, 6'd3, 96'hF);
    for (int c = 0; c < 4; c++) begin
      chk("stall_payload", 0, iss_payload[0],    96'hD);
      chk("stall_valid",   0, PW'(iss_valid[0]), PW'(1));
      chk("stall_count",   0, PW'(count[0]),     PW'(2));
      step();
    end
    Issue_Hold = 1'b1;
    Iss_Ready  = 1'b1;
    step();
    chk("hold_drained_valid", 0, PW'(iss_valid[0]), '0);
    chk("hold_count",         0, PW'(count[0]),     PW'(2));
    step();
    chk("hold_no_load",       1, PW'(iss_valid[1]), '0);
    Issue_Hold = 1'b0;
    wait_drain(40, "drain_hold");

    // Flush with a loaded output stage, five waiting entries and a concurrent offer.
    Iss_Ready = 1'b0;
    enq(6'd1, 6'd1, 96'h50);
    Wake_List[5] = 1'b0;
    for (int i = 0; i < 5; i++) enq(6'd5, 6'd5, PW'(32'h500 + i));
    chk("preflush_count", 0, PW'(count[0]),     PW'(5));
    chk("preflush_valid", 0, PW'(iss_valid[0]), PW'(1));
    Flush       = 1'b1;
    Enq_Valid   = 1'b1;
    Enq_Src1    = 6'd1;
    Enq_Src2    = 6'd1;
    Enq_Payload = 96'h5FF;
    step();
    Flush     = 1'b0;
    Enq_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("flush_count", k, PW'(count[k]),     '0);
      chk("flush_valid", k, PW'(iss_valid[k]), '0);
    end
    Wake_List = '1;
    Iss_Ready = 1'b1;
    repeat (4) step();
    chk("flush_absent", 0, PW'(count[0]), '0);

    // Asynchronous reset pulse in the middle of a cycle.
    Iss_Ready = 1'b0;
    enq(6'd1, 6'd1, 96'h60);
    enq(6'd2, 6'd2, 96'h61);
    step();
    chk("prerst_count", 0, PW'(count[0]),     PW'(1));
    chk("prerst_valid", 0, PW'(iss_valid[0]), PW'(1));
    #2;
    Rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_count",   k, PW'(count[k]),     '0);
      chk("async_rst_valid",   k, PW'(iss_valid[k]), '0);
      chk("async_rst_empty",   k, PW'(empty[k]),     PW'(1));
      chk("async_rst_payload", k, iss_payload[k],    '0);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (2) step();
    chk("post_rst_empty", 0, PW'(empty[0]), PW'(1));

    chk("leftover_exp",    0, PW'(exp_q.size()),    '0);
    chk("leftover_exp_io", 1, PW'(exp_q_io.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
